// File: rtl/chacha_param_pkg.sv
// Shared constants, FSM state encoding and width helper for the ChaCha20
// key/nonce/counter acquisition sequencer.
package chacha_param_pkg;

    localparam logic [1:0] CT_KEY     = 2'b00;
    localparam logic [1:0] CT_NONCE   = 2'b01;
    localparam logic [1:0] CT_COUNTER = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TYPE    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_KEY   = 3'd1,
        S_LOAD_NONCE = 3'd2,
        S_LOAD_CTR   = 3'd3,
        S_DONE       = 3'd4,
        S_ERR        = 3'd5
    } state_t;

    // Index width for the longest field; never narrower than one bit.
    function automatic int idx_width(input int k, input int n, input int c);
        int m;
        m = k;
        if (n > m) m = n;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/param_word_collector.sv
// One parameter field register, written a word at a time by index; the
// counter instance can also increment the whole field as one integer.
module param_word_collector
    import chacha_param_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 3,
    parameter bit INC_EN = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_we,
    input  logic [IDX_W-1:0]          i_idx,
    input  logic [WORD_W-1:0]         i_wdata,
    input  logic                      i_inc,
    output logic [WORDS*WORD_W-1:0]   o_field
);

    localparam int FIELD_W = WORDS * WORD_W;

    logic [FIELD_W-1:0] r_field;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_field <= '0;
        end else if (i_we) begin
            for (int i = 0; i < WORDS; i++) begin
                if (i_idx == IDX_W'(i)) r_field[i*WORD_W +: WORD_W] <= i_wdata;
            end
        end else if (INC_EN && i_inc) begin
            r_field <= r_field + FIELD_W'(1);
        end
    end

    assign o_field = r_field;

endmodule

// File: rtl/chacha_param_loader.sv
// Acquisition sequencer gathering key, nonce and block counter word by word
// from the chunk stream or the TRNG before the ChaCha20 core runs.
module chacha_param_loader
    import chacha_param_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int KEY_WORDS   = 8,
    parameter int NONCE_WORDS = 3,
    parameter int CTR_WORDS   = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int IDX_W       = idx_width(KEY_WORDS, NONCE_WORDS, CTR_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [2:0]                    use_stream,
    input  logic                          ctr_inc,
    input  logic                          chunk_valid,
    input  logic [1:0]                    chunk_type,
    input  logic [WORD_W-1:0]             chunk,
    output logic                          chunk_request,
    output logic [1:0]                    request_type,
    output logic [IDX_W-1:0]              chunk_index,
    output logic                          trng_req,
    input  logic                          trng_valid,
    input  logic [WORD_W-1:0]             trng_data,
    output logic [KEY_WORDS*WORD_W-1:0]   key,
    output logic [NONCE_WORDS*WORD_W-1:0] nonce,
    output logic [CTR_WORDS*WORD_W-1:0]   counter,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [1:0]                    err_code,
    output logic [2:0]                    dbg_state
);

    localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    logic [2:0]         r_src;
    logic [IDX_W-1:0]   r_idx;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_error;
    logic [1:0]         r_err_code;

    logic               w_loading;
    logic               w_stream;
    logic [1:0]         w_field_code;
    logic               w_last;
    state_t             w_next;
    logic               w_accept;
    logic               w_mismatch;
    logic               w_timeout;
    logic [WORD_W-1:0]  w_wdata;

    always_comb begin
        w_loading    = 1'b0;
        w_stream     = 1'b0;
        w_field_code = CT_KEY;
        w_last       = 1'b0;
        w_next       = S_IDLE;
        case (r_state)
            S_LOAD_KEY: begin
                w_loading    = 1'b1;
                w_stream     = r_src[0];
                w_field_code = CT_KEY;
                w_last       = (r_idx == IDX_W'(KEY_WORDS - 1));
                w_next       = S_LOAD_NONCE;
            end
            S_LOAD_NONCE: begin
                w_loading    = 1'b1;
                w_stream     = r_src[1];
                w_field_code = CT_NONCE;
                w_last       = (r_idx == IDX_W'(NONCE_WORDS - 1));
                w_next       = S_LOAD_CTR;
            end
            S_LOAD_CTR: begin
                w_loading    = 1'b1;
                w_stream     = r_src[2];
                w_field_code = CT_COUNTER;
                w_last       = (r_idx == IDX_W'(CTR_WORDS - 1));
                w_next       = S_DONE;
            end
            default: ;
        endcase
    end

    // Handshake: while chunk_request (or trng_req) is high the loader is ready;
    // a word transfers on any clk edge where the matching valid is also high
    // (and, for the stream, chunk_type equals request_type). No skid buffer.
    assign w_accept   = w_stream ? (chunk_valid && (chunk_type == w_field_code))
                                 : (w_loading && trng_valid);
    assign w_mismatch = w_stream && chunk_valid && (chunk_type != w_field_code);
    assign w_timeout  = (TIMEOUT_CYC != 0) && ((32'(r_tmo) + 32'd1) == 32'(TIMEOUT_CYC));
    assign w_wdata    = w_stream ? chunk : trng_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD_KEY;
                        r_src      <= use_stream;
                        r_idx      <= '0;
                        r_tmo      <= '0;
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
                    end
                end
                S_LOAD_KEY, S_LOAD_NONCE, S_LOAD_CTR: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_idx   <= '0;
                        r_tmo   <= '0;
                    end else if (w_mismatch) begin
                        r_state    <= S_ERR;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TYPE;
                        r_idx      <= '0;
                        r_tmo      <= '0;
                    end else if (w_accept) begin
                        r_tmo <= '0;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= w_next;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_ERR;
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_idx      <= '0;
                        r_tmo      <= '0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // abort outranks a same-cycle accept, so it also blocks the field write.
    logic w_we_key, w_we_nonce, w_we_ctr, w_ctr_inc;
    assign w_we_key   = w_accept && !abort && (r_state == S_LOAD_KEY);
    assign w_we_nonce = w_accept && !abort && (r_state == S_LOAD_NONCE);
    assign w_we_ctr   = w_accept && !abort && (r_state == S_LOAD_CTR);
    assign w_ctr_inc  = (r_state == S_IDLE) && ctr_inc && !start;

    param_word_collector #(.WORDS(KEY_WORDS), .WORD_W(WORD_W), .IDX_W(IDX_W), .INC_EN(1'b0)) u_key (
        .clk(clk), .rst(rst), .i_we(w_we_key), .i_idx(r_idx), .i_wdata(w_wdata),
        .i_inc(1'b0), .o_field(key)
    );

    param_word_collector #(.WORDS(NONCE_WORDS), .WORD_W(WORD_W), .IDX_W(IDX_W), .INC_EN(1'b0)) u_nonce (
        .clk(clk), .rst(rst), .i_we(w_we_nonce), .i_idx(r_idx), .i_wdata(w_wdata),
        .i_inc(1'b0), .o_field(nonce)
    );

    param_word_collector #(.WORDS(CTR_WORDS), .WORD_W(WORD_W), .IDX_W(IDX_W), .INC_EN(1'b1)) u_ctr (
        .clk(clk), .rst(rst), .i_we(w_we_ctr), .i_idx(r_idx), .i_wdata(w_wdata),
        .i_inc(w_ctr_inc), .o_field(counter)
    );

    assign chunk_request = w_stream;
    assign trng_req      = w_loading && !w_stream;
    assign request_type  = w_field_code;
    assign chunk_index   = w_loading ? r_idx : '0;
    assign busy          = w_loading;
    assign done          = (r_state == S_DONE);
    assign error         = r_error;
    assign err_code      = r_err_code;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_chacha_param_loader.sv
// Directed bench for chacha_param_loader: a word-array model of the
// acquisition rules is checked every cycle, plus hand-computed literals.
module tb_chacha_param_loader;
    import chacha_param_pkg::*;

    localparam int W = 32, K = 8, N = 3, C = 1, TMO = 16;

    logic clk = 1'b0;
    logic rst, start, abort, ctr_inc, chunk_valid, trng_valid;
    logic [2:0] use_stream;
    logic [1:0] chunk_type;
    logic [W-1:0] chunk, trng_data;
    logic chunk_request, trng_req, busy, done, error;
    logic [1:0] request_type, err_code;
    logic [2:0] chunk_index, dbg_state;
    logic [K*W-1:0] key;
    logic [N*W-1:0] nonce;
    logic [C*W-1:0] counter;

    chacha_param_loader #(
        .WORD_W(W), .KEY_WORDS(K), .NONCE_WORDS(N), .CTR_WORDS(C), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .use_stream(use_stream),
        .ctr_inc(ctr_inc), .chunk_valid(chunk_valid), .chunk_type(chunk_type), .chunk(chunk),
        .chunk_request(chunk_request), .request_type(request_type), .chunk_index(chunk_index),
        .trng_req(trng_req), .trng_valid(trng_valid), .trng_data(trng_data),
        .key(key), .nonce(nonce), .counter(counter), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DONE = 2, PH_ERR = 3;
    int lens[3] = '{K, N, C};
    bit m_live = 1'b0;
    int m_ph, m_field, m_word, m_stall;
    bit [2:0] m_src;
    bit m_fs, m_carry;
    logic m_err;
    logic [1:0] m_code;
    logic [W-1:0] m_k[K], m_n[N], m_c[C];

    function automatic logic [255:0] m_pack(input int f);
        logic [255:0] v;
        v = '0;
        if (f == 0) for (int i = 0; i < K; i++) v[i*W +: W] = m_k[i];
        if (f == 1) for (int i = 0; i < N; i++) v[i*W +: W] = m_n[i];
        if (f == 2) for (int i = 0; i < C; i++) v[i*W +: W] = m_c[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1'b1; m_ph = PH_IDLE; m_field = 0; m_word = 0; m_stall = 0;
            m_src = '0; m_err = 1'b0; m_code = 2'b00;
            for (int i = 0; i < K; i++) m_k[i] = '0;
            for (int i = 0; i < N; i++) m_n[i] = '0;
            for (int i = 0; i < C; i++) m_c[i] = '0;
        end else if (m_live) begin
            case (m_ph)
                PH_IDLE: begin
                    if (start) begin
                        m_src = use_stream; m_err = 1'b0; m_code = 2'b00;
                        m_ph = PH_LOAD; m_field = 0; m_word = 0; m_stall = 0;
                    end else if (ctr_inc) begin
                        m_carry = 1'b1;
                        for (int i = 0; i < C; i++) begin
                            if (m_carry) begin
                                m_c[i] = m_c[i] + 1;
                                m_carry = (m_c[i] == 0);
                            end
                        end
                    end
                end
                PH_LOAD: begin
                    m_fs = m_src[m_field];
                    if (abort) begin
                        m_ph = PH_IDLE;
                    end else if (m_fs && chunk_valid && chunk_type != 2'(m_field)) begin
                        m_ph = PH_ERR; m_err = 1'b1; m_code = 2'b01;
                    end else if (m_fs ? chunk_valid : trng_valid) begin
                        if (m_field == 0) m_k[m_word] = m_fs ? chunk : trng_data;
                        if (m_field == 1) m_n[m_word] = m_fs ? chunk : trng_data;
                        if (m_field == 2) m_c[m_word] = m_fs ? chunk : trng_data;
                        m_stall = 0;
                        m_word++;
                        if (m_word == lens[m_field]) begin
                            m_word = 0;
                            m_field++;
                            if (m_field == 3) m_ph = PH_DONE;
                        end
                    end else begin
                        m_stall++;
                        if (TMO != 0 && m_stall == TMO) begin
                            m_ph = PH_ERR; m_err = 1'b1; m_code = 2'b10;
                        end
                    end
                end
                default: m_ph = PH_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", 256'(busy), 256'(m_ph == PH_LOAD));
            chk("done", 256'(done), 256'(m_ph == PH_DONE));
            chk("chunk_request", 256'(chunk_request), 256'((m_ph == PH_LOAD) ? m_src[m_field] : 1'b0));
            chk("trng_req", 256'(trng_req), 256'((m_ph == PH_LOAD) ? !m_src[m_field] : 1'b0));
            chk("request_type", 256'(request_type), 256'((m_ph == PH_LOAD) ? m_field : 0));
            chk("chunk_index", 256'(chunk_index), 256'((m_ph == PH_LOAD) ? m_word : 0));
            chk("error", 256'(error), 256'(m_err));
            chk("err_code", 256'(err_code), 256'(m_code));
            chk("key", 256'(key), m_pack(0));
            chk("nonce", 256'(nonce), m_pack(1));
            chk("counter", 256'(counter), m_pack(2));
        end
    end

    always @(negedge clk) if (done === 1'b1) done_seen++;

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [W-1:0] d);
        chunk_valid = 1'b1; chunk_type = t; chunk = d;
        tick();
        chunk_valid = 1'b0;
    endtask

    // All-TRNG acquisition; TRNG word for cycle n is base+n. Returns at DONE.
    task automatic run_trng(input logic [W-1:0] base, output int done_cyc, output int treqs,
                            output logic busy_d, output logic err1);
        use_stream = 3'b000; trng_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        done_cyc = 0; treqs = 0; busy_d = 1'b1; err1 = error;
        for (int n = 1; n <= 20 && done_cyc == 0; n++) begin
            if (done) begin
                done_cyc = n; busy_d = busy;
            end else begin
                if (trng_req) treqs++;
                trng_data = base + W'(n);
                tick();
            end
        end
        trng_valid = 1'b0;
    endtask

    // All-stream acquisition, back to back. Returns in the DONE cycle.
    task automatic run_stream(input logic [W-1:0] kb, input logic [W-1:0] nb, input logic [W-1:0] cb);
        use_stream = 3'b111; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < K; i++) send(CT_KEY, kb + W'(i));
        for (int i = 0; i < N; i++) send(CT_NONCE, nb + W'(i));
        for (int i = 0; i < C; i++) send(CT_COUNTER, cb + W'(i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcyc, treqs, ecyc, d0;
        logic busy_d, err1;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ctr_inc = 1'b0; use_stream = '0;
        chunk_valid = 1'b0; chunk_type = '0; chunk = '0; trng_valid = 1'b0; trng_data = '0;
        repeat (3) tick();
        chk("rst_key", 256'(key), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_state", 256'(dbg_state), 256'(S_IDLE));
        rst = 1'b0;
        tick();

        // 1: all TRNG, done in cycle 13
        run_trng(32'hA000_0000, dcyc, treqs, busy_d, err1);
        chk("t1_done_cycle", 256'(dcyc), 256'd13);
        chk("t1_trng_req_cycles", 256'(treqs), 256'd12);
        chk("t1_busy_at_done", 256'(busy_d), 256'd0);
        chk("t1_key_w0", 256'(key[31:0]), 256'h A000_0001);
        chk("t1_key_w1", 256'(key[63:32]), 256'h A000_0002);
        chk("t1_nonce_w0", 256'(nonce[31:0]), 256'h A000_0009);
        chk("t1_counter", 256'(counter), 256'h A000_000C);
        tick();

        // 2: all stream, back to back
        d0 = done_seen;
        run_stream(32'h4000_0000, 32'h5000_0000, 32'h6000_0000);
        chk("t2_done_at_13", 256'(done), 256'd1);
        chk("t2_key", 256'(key),
            256'h40000007_40000006_40000005_40000004_40000003_40000002_40000001_40000000);
        chk("t2_nonce", 256'(nonce), 256'h50000002_50000001_50000000);
        chk("t2_counter", 256'(counter), 256'h6000_0000);
        tick();
        chk("t2_done_low", 256'(done), 256'd0);
        chk("t2_done_pulses", 256'(done_seen - d0), 256'd1);

        // 3: type mismatch at key index 3
        d0 = done_seen;
        use_stream = 3'b001; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(CT_KEY, 32'h7000_0000 + W'(i));
        send(CT_NONCE, 32'h7000_AAAA);
        chk("t3_error", 256'(error), 256'd1);
        chk("t3_err_code", 256'(err_code), 256'h1);
        chk("t3_busy", 256'(busy), 256'd0);
        tick();
        chk("t3_error_held", 256'(error), 256'd1);
        chk("t3_no_done", 256'(done_seen - d0), 256'd0);
        run_trng(32'hC000_0000, dcyc, treqs, busy_d, err1);
        chk("t3_error_cleared", 256'(err1), 256'd0);
        chk("t3_rerun_done_cycle", 256'(dcyc), 256'd13);
        tick();

        // 4: timeout on a streamed nonce
        d0 = done_seen;
        use_stream = 3'b010; trng_valid = 1'b1; trng_data = 32'h1234_5678; start = 1'b1;
        tick();
        start = 1'b0;
        ecyc = 0;
        for (int n = 1; n <= 40 && ecyc == 0; n++) begin
            if (error) ecyc = n;
            else tick();
        end
        chk("t4_err_cycle", 256'(ecyc), 256'd25);
        chk("t4_err_code", 256'(err_code), 256'h2);
        trng_valid = 1'b0;
        tick();
        chk("t4_no_done", 256'(done_seen - d0), 256'd0);

        // 5: abort at key index 4, with a same-cycle valid word
        d0 = done_seen;
        use_stream = 3'b111; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send(CT_KEY, 32'hD000_0000 + W'(i));
        abort = 1'b1;
        send(CT_KEY, 32'hDEAD_BEEF);
        abort = 1'b0;
        chk("t5_busy", 256'(busy), 256'd0);
        chk("t5_error", 256'(error), 256'd0);
        chk("t5_key_w3", 256'(key[127:96]), 256'h D000_0003);
        chk("t5_key_w4_kept", 256'(key[159:128]), 256'h1234_5678);
        chk("t5_no_done", 256'(done_seen - d0), 256'd0);
        run_stream(32'hE000_0000, 32'hE100_0000, 32'hE200_0000);
        chk("t5_rerun_done", 256'(done), 256'd1);
        chk("t5_rerun_key_w0", 256'(key[31:0]), 256'h E000_0000);
        tick();

        // 6: counter wrap via ctr_inc; ctr_inc ignored with start and during load
        use_stream = 3'b100; trng_valid = 1'b1; ctr_inc = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            trng_data = 32'hB000_0000 + W'(n);
            if (n == 9) ctr_inc = 1'b0;
            tick();
        end
        trng_valid = 1'b0;
        chk("t6_ctr_held", 256'(counter), 256'h E200_0000);
        send(CT_COUNTER, 32'hFFFF_FFFF);
        chk("t6_ctr_loaded", 256'(counter), 256'h FFFF_FFFF);
        tick();
        ctr_inc = 1'b1;
        tick();
        ctr_inc = 1'b0;
        chk("t6_ctr_wrap", 256'(counter), 256'd0);
        chk("t6_key_w0", 256'(key[31:0]), 256'h B000_0001);
        chk("t6_key_w7", 256'(key[255:224]), 256'h B000_0008);
        chk("t6_nonce_w2", 256'(nonce[95:64]), 256'h B000_000B);
        ctr_inc = 1'b1;
        tick();
        ctr_inc = 1'b0;
        chk("t6_ctr_plus1", 256'(counter), 256'd1);

        // reset in the middle of a load
        use_stream = 3'b111; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(CT_KEY, 32'hF000_0000 + W'(i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_key", 256'(key), 256'd0);
        chk("rst_mid_busy", 256'(busy), 256'd0);
        chk("rst_mid_state", 256'(dbg_state), 256'(S_IDLE));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chacha_param_loader.md
Name: chacha_param_loader

Overview:
Parametrised acquisition sequencer that gathers the ChaCha20 key, nonce and block counter before the core runs. Each field comes word-by-word either from the external chunk stream or from the on-chip TRNG, selected per field. It generalises the fixed 8/3/1-word streaming front end of asic_top with:
- configurable word width and word counts
- a stall timeout
- chunk-type checking with error reporting
- abort
- a counter auto-increment mode for multi-block messages

It sits between the chip pins / TRNG and the ChaCha20 core.

Parameters:
WORD_W, 32, width of one chunk / TRNG word
KEY_WORDS, 8, key length in words (>=1)
NONCE_WORDS, 3, nonce length in words (>=1)
CTR_WORDS, 1, counter length in words (>=1)
TIMEOUT_CYC, 1024, max idle cycles waiting for one word; 0 disables timeout
IDX_W, derived = clog2(max(KEY_WORDS,NONCE_WORDS,CTR_WORDS)), chunk_index width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin acquisition (sampled in IDLE only)
abort  in  1  cancel acquisition, return to IDLE
use_stream  in  3  per-field source select: bit0 key, bit1 nonce, bit2 counter; 1 = stream, 0 = TRNG; latched at start
ctr_inc  in  1  increment loaded counter (IDLE only)
chunk_valid  in  1  stream word present
chunk_type  in  2  type of presented word
chunk  in  WORD_W  stream word
chunk_request  out  1  loader is waiting for a stream word
request_type  out  2  field requested: 00 key, 01 nonce, 10 counter
chunk_index  out  IDX_W  word index within the requested field
trng_req  out  1  loader is waiting for a TRNG word
trng_valid  in  1  TRNG word present
trng_data  in  WORD_W  TRNG word
key  out  KEY_WORDS*WORD_W  assembled key
nonce  out  NONCE_WORDS*WORD_W  assembled nonce
counter  out  CTR_WORDS*WORD_W  assembled counter
busy  out  1  acquisition in progress
done  out  1  one-cycle pulse when all fields are loaded
error  out  1  sticky error flag; cleared on the next accepted start or on rst
err_code  out  2  00 none, 01 type mismatch, 10 timeout

Behaviour:
- Reset: state IDLE; all outputs 0, including key/nonce/counter; timeout counter 0.
- FSM states: IDLE -> LOAD_KEY -> LOAD_NONCE -> LOAD_CTR -> DONE -> IDLE. Any LOAD state can go to ERR (then IDLE next cycle) or, on abort, straight to IDLE.
- IDLE:
  - start=1: latch use_stream, clear error/err_code, word index=0, go to LOAD_KEY.
  - start and ctr_inc together: start wins.
  - start while busy is ignored.
- LOAD states are Moore outputs:
  - busy=1.
  - Streamed field: chunk_request=1, request_type=field code, chunk_index=current index, trng_req=0.
  - TRNG field: trng_req=1, chunk_request=0, request_type=field code, chunk_index=index.
- Word acceptance:
  - Streamed field: a word is accepted on a clk edge with chunk_valid=1 and chunk_type==request_type.
  - TRNG field: a word is accepted on trng_valid=1.
  - Word i is stored at field bits [i*WORD_W +: WORD_W], word 0 least significant.
  - At most one word per cycle; back-to-back accepts are allowed when valid is held.
  - After the last word of a field, the next state is the next field (index reset to 0) or DONE.
- Type mismatch: chunk_valid=1 with a wrong chunk_type in a streamed LOAD state -> ERR, err_code=01. chunk_valid during a TRNG field or in IDLE is ignored.
- Timeout: the counter increments each LOAD cycle without an accept and resets on accept and on state change. When it reaches TIMEOUT_CYC (if nonzero) -> ERR, err_code=10.
- ERR (one cycle): busy=0, error=1. Then IDLE; error and err_code hold. key/nonce/counter keep any partially written words; done is never pulsed.
- abort in a LOAD state: next state IDLE, busy=0, no done, error unchanged. abort has priority over a same-cycle accept, mismatch or timeout.
- DONE (one cycle): done=1, busy=0. key/nonce/counter hold until overwritten by a later acquisition.
- Latency with all sources always valid: start sampled at edge 0; words accepted in cycles 1..(K+N+C); done high in cycle K+N+C+1. Defaults: done in cycle 13.
- ctr_inc in IDLE: counter <= counter+1 modulo 2^(CTR_WORDS*WORD_W), wrapping to 0. Ignored outside IDLE.
- rst has priority over everything, including mid-operation.

Decomposition:
- Package chacha_param_pkg:
  - chunk-type constants KEY=2'b00, NONCE=2'b01, COUNTER=2'b10
  - err_code constants
  - FSM state enum
- Sub-module param_word_collector, instantiated three times (key, nonce, counter), parametrised by WORDS/WORD_W. It holds the field register, the word write-enable by index, and the increment logic (counter instance only).

Test Plan:
1. use_stream=000, trng_valid=1 constant, trng_data=cycle count -> trng_req for 12 cycles, done in cycle 13, key word0 = first TRNG word, busy low at done.
2. use_stream=111, back-to-back key 0x40000000+i, nonce 0x50000000+i, counter 0x60000000 -> key=0x40000007...40000000 (word 0 least significant), nonce=0x500000025000000150000000, counter=0x60000000, done one pulse.
3. use_stream=001; at key index 3 drive chunk_valid with chunk_type=01 -> ERR, error=1, err_code=01, no done; the next start clears error.
4. TIMEOUT_CYC=16, use_stream=010, no chunk_valid during nonce -> error with err_code=10 exactly 16 cycles after entering LOAD_NONCE.
5. abort at key index 4 (streamed) -> busy=0 next cycle, no done, error=0; a new start completes normally.
6. Load counter 0xFFFFFFFF via stream, then ctr_inc for one cycle in IDLE -> counter=0x00000000, key/nonce unchanged; ctr_inc during LOAD is ignored.
